// File: rtl/fp_add_pkg.sv
// rtl/fp_add_pkg.sv - shared state encoding and IEEE-754 single field constants
package fp_add_pkg;
  localparam int XLEN_DEF = 32;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam logic [7:0] EXP_ZERO = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;
endpackage

// File: rtl/floating_point_cla.sv
// rtl/floating_point_cla.sv - combinational single-precision adder (truncating, flush-to-zero)
module floating_point_cla
  import fp_add_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] sum
);
  localparam int MW = EXP_LSB;
  localparam int EW = EXP_MSB - EXP_LSB + 1;

  logic [XLEN-1:0] big, sml;
  logic [EW-1:0]   eb, es, ediff;
  logic [MW:0]     mb, ms, msh, mnorm;
  logic [MW+1:0]   raw;
  logic [EW+1:0]   eres;
  logic [4:0]      lz;
  logic            found;

  always_comb begin
    // Larger magnitude first so the subtract path never borrows
    if (a[EXP_MSB:0] >= b[EXP_MSB:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    eb    = big[EXP_MSB:EXP_LSB];
    es    = sml[EXP_MSB:EXP_LSB];
    mb    = {|eb, big[MW-1:0]};
    ms    = {|es, sml[MW-1:0]};
    ediff = eb - es;
    msh   = (ediff > EW'(MW)) ? '0 : (ms >> ediff);
    raw   = (big[XLEN-1] == sml[XLEN-1]) ? ({1'b0, mb} + {1'b0, msh})
                                         : ({1'b0, mb} - {1'b0, msh});
    lz    = '0;
    found = 1'b0;
    for (int i = MW; i >= 0; i--) begin
      if (!found && raw[i]) begin
        lz    = 5'(MW - i);
        found = 1'b1;
      end
    end
    if (raw[MW+1]) begin
      mnorm = raw[MW+1:1];
      eres  = {2'b00, eb} + 1'b1;
    end else begin
      mnorm = raw[MW:0] << lz;
      eres  = {2'b00, eb} - {5'b00000, lz};
    end
    sum = {big[XLEN-1], eres[EW-1:0], mnorm[MW-1:0]};
    if (raw == '0)
      sum = '0;
    else if (!raw[MW+1] && ({3'b000, lz} >= eb))
      sum = {big[XLEN-1], EXP_ZERO, {MW{1'b0}}};
    else if (eres >= (EW+2)'(EXP_MAX))
      sum = {big[XLEN-1], EXP_MAX, {MW{1'b0}}};
  end
endmodule

// File: rtl/fp_add_arbiter_rr.sv
// rtl/fp_add_arbiter_rr.sv - combinational round-robin picker starting the scan at ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  logic [IDW:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = {1'b0, ptr} + (IDW+1)'(k);
      if (j >= (IDW+1)'(NREQ))
        j = j - (IDW+1)'(NREQ);
      if (!any && req[j[IDW-1:0]]) begin
        grant[j[IDW-1:0]] = 1'b1;
        idx               = j[IDW-1:0];
        any               = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin sharing of one FP adder; FP_ADD_ARB_FLAGS_EN adds ovf/unf flags
module fp_add_arbiter
  import fp_add_pkg::*;
#(
  parameter int  XLEN = XLEN_DEF,
  parameter int  NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [XLEN-1:0]      resp_data,
  output logic [IDW-1:0]       resp_id
`ifdef FP_ADD_ARB_FLAGS_EN
  ,
  output logic                 resp_ovf,
  output logic                 resp_unf
`endif
);
  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, gidx, op_id;
  logic [NREQ-1:0] grant;
  logic            gany;
  logic [XLEN-1:0] op_a, op_b, sum;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  floating_point_cla #(.XLEN(XLEN)) u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      S_IDLE: begin
        req_ready = grant;
        if (gany) state_nxt = S_EXEC;
      end
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (resp_valid && resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
`ifdef FP_ADD_ARB_FLAGS_EN
      resp_ovf   <= 1'b0;
      resp_unf   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (gany) begin
          op_a  <= req_a[int'(gidx)*XLEN +: XLEN];
          op_b  <= req_b[int'(gidx)*XLEN +: XLEN];
          op_id <= gidx;
          ptr   <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
        end
        S_EXEC: begin
          resp_data  <= sum;
          resp_id    <= op_id;
          resp_valid <= 1'b1;
`ifdef FP_ADD_ARB_FLAGS_EN
          resp_ovf   <= (sum[EXP_MSB:EXP_LSB] == EXP_MAX);
          resp_unf   <= (sum[EXP_MSB:EXP_LSB] == EXP_ZERO);
`endif
        end
        S_RESP: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - scoreboard bench for fp_add_arbiter (optionally FP_ADD_ARB_FLAGS_EN)
module tb_fp_add_arbiter;
  localparam int NREQ = 4;
  localparam int M_IDLE = 0, M_EXEC = 1, M_RESP = 2;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } op_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [NREQ*32-1:0] req_a, req_b;
  logic               resp_valid, resp_ready;
  logic [31:0]        resp_data;
  logic [1:0]         resp_id;
`ifdef FP_ADD_ARB_FLAGS_EN
  logic               resp_ovf, resp_unf;
`endif

  fp_add_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
`ifdef FP_ADD_ARB_FLAGS_EN
    ,
    .resp_ovf   (resp_ovf),
    .resp_unf   (resp_unf)
`endif
  );

  always #5 clk = ~clk;

  int  vectors = 0;
  int  miscompares = 0;
  op_t pend[$];
  op_t sb[$];
  int  got_ids[$];
  int  mstate = M_IDLE;
  int  mptr = 0;
  bit  acc_valid = 0;
  int  acc_idx = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_op(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] s);
    op_t o;
    o.id = id; o.a = a; o.b = b; o.sum = s;
    pend.push_back(o);
  endtask

  task automatic retire(input int id);
    for (int k = 0; k < pend.size(); k++) begin
      if (pend[k].id == id) begin
        pend.delete(k);
        return;
      end
    end
  endtask

  task automatic drive_reqs();
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < pend.size(); k++) begin
        if (pend[k].id == i && !req_valid[i]) begin
          req_valid[i]       = 1'b1;
          req_a[i*32 +: 32]  = pend[k].a;
          req_b[i*32 +: 32]  = pend[k].b;
        end
      end
    end
  endtask

  task automatic sample();
    int g;
    logic [NREQ-1:0] exp_rdy;
    if (rst) begin
      sb.delete();
      mstate    = M_IDLE;
      mptr      = 0;
      acc_valid = 0;
      return;
    end
    check("resp_valid", 32'(resp_valid), 32'(mstate == M_RESP));
    case (mstate)
      M_IDLE: begin
        g = -1;
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (g >= 0) begin
          for (int k = 0; k < pend.size(); k++) begin
            if (pend[k].id == g) begin
              sb.push_back(pend[k]);
              break;
            end
          end
          acc_valid = 1;
          acc_idx   = g;
          mptr      = (g + 1) % NREQ;
          mstate    = M_EXEC;
        end
      end
      M_EXEC: begin
        check("req_ready_exec", 32'(req_ready), 32'd0);
        mstate = M_RESP;
      end
      default: begin
        check("req_ready_resp", 32'(req_ready), 32'd0);
        check("resp_data", resp_data, sb[0].sum);
        check("resp_id", 32'(resp_id), 32'(sb[0].id));
`ifdef FP_ADD_ARB_FLAGS_EN
        check("resp_ovf", 32'(resp_ovf), 32'(sb[0].sum[30:23] == 8'hFF));
        check("resp_unf", 32'(resp_unf), 32'(sb[0].sum[30:23] == 8'h00));
`endif
        if (resp_ready) begin
          got_ids.push_back(sb[0].id);
          void'(sb.pop_front());
          mstate = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic step();
    if (acc_valid) begin
      retire(acc_idx);
      acc_valid = 0;
    end
    drive_reqs();
    #2;
    sample();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((pend.size() != 0 || sb.size() != 0 || mstate != M_IDLE || acc_valid) && n < budget) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(pend.size() != 0 || sb.size() != 0 || mstate != M_IDLE), 32'd0);
  endtask

  task automatic wait_mstate(input int target, input int budget);
    int n = 0;
    while (mstate != target && n < budget) begin
      step();
      n++;
    end
    check("state_timeout", 32'(mstate), 32'(target));
  endtask

  initial begin
    int e2[5] = '{0, 1, 2, 3, 0};
    int e3[2] = '{0, 1};
    int e5[2] = '{0, 2};
    rst = 1'b1; resp_ready = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_data", resp_data, 32'd0);
    check("rst_id", 32'(resp_id), 32'd0);
`ifdef FP_ADD_ARB_FLAGS_EN
    check("rst_flags", {30'd0, resp_ovf, resp_unf}, 32'd0);
`endif

    // 1.5 + 1.5 with immediate acceptance
    add_op(0, 32'h3FC00000, 32'h3FC00000, 32'h40400000);
    run_idle(50);

    // All four requesting from ptr 0
    rst = 1'b1; step(); rst = 1'b0;
    got_ids.delete();
    add_op(0, 32'h3F800000, 32'h3F800000, 32'h40000000);
    add_op(1, 32'h3F800000, 32'h40000000, 32'h40400000);
    add_op(2, 32'h40000000, 32'h40000000, 32'h40800000);
    add_op(3, 32'h3F000000, 32'h3E800000, 32'h3F400000);
    add_op(0, 32'h40400000, 32'hBF800000, 32'h40000000);
    run_idle(100);
    check("order_cnt", 32'(got_ids.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_ids.size(); i++) check("order", 32'(got_ids[i]), 32'(e2[i]));

    // Move ptr to 2, then 0 and 1 request together
    add_op(1, 32'h3F800000, 32'h3F800000, 32'h40000000);
    run_idle(50);
    got_ids.delete();
    add_op(0, 32'h40000000, 32'h3F800000, 32'h40400000);
    add_op(1, 32'h3F000000, 32'h3F000000, 32'h3F800000);
    run_idle(50);
    check("wrap_cnt", 32'(got_ids.size()), 32'd2);
    for (int i = 0; i < 2 && i < got_ids.size(); i++) check("wrap", 32'(got_ids[i]), 32'(e3[i]));

    // Back-pressure: consumer stalls five cycles in RESP
    resp_ready = 1'b0;
    add_op(2, 32'h40800000, 32'h40800000, 32'h41000000);
    add_op(3, 32'h3F800000, 32'hBF000000, 32'h3F000000);
    wait_mstate(M_RESP, 20);
    for (int i = 0; i < 5; i++) step();
    resp_ready = 1'b1;
    run_idle(50);

    // Reset while the operation is in EXEC
    got_ids.delete();
    add_op(1, 32'h3F800000, 32'h3F800000, 32'h40000000);
    wait_mstate(M_EXEC, 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_exec_valid", 32'(resp_valid), 32'd0);
    step();
    add_op(2, 32'h40000000, 32'h40000000, 32'h40800000);
    add_op(0, 32'h3F800000, 32'h3F800000, 32'h40000000);
    run_idle(50);
    check("rst_exec_cnt", 32'(got_ids.size()), 32'd2);
    for (int i = 0; i < 2 && i < got_ids.size(); i++) check("rst_exec_id", 32'(got_ids[i]), 32'(e5[i]));

    // Exponent extremes: overflow to infinity and exact cancellation
    add_op(3, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    add_op(0, 32'h3F800000, 32'hBF800000, 32'h00000000);
    run_idle(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
